// File: rtl/aec_pkg.sv
// Shared token codes, ASCII constants, FSM encoding and token-to-ASCII map for the expression transmitter.
package aec_pkg;

   localparam logic [4:0] TOK_LPAR = 5'd16;
   localparam logic [4:0] TOK_RPAR = 5'd17;
   localparam logic [4:0] TOK_MUL  = 5'd18;
   localparam logic [4:0] TOK_ADD  = 5'd19;
   localparam logic [4:0] TOK_SUB  = 5'd20;

   localparam logic [7:0] ASCII_0    = 8'd48;
   localparam logic [7:0] ASCII_A    = 8'd97;
   localparam logic [7:0] ASCII_LPAR = 8'd40;
   localparam logic [7:0] ASCII_RPAR = 8'd41;
   localparam logic [7:0] ASCII_MUL  = 8'd42;
   localparam logic [7:0] ASCII_ADD  = 8'd43;
   localparam logic [7:0] ASCII_SUB  = 8'd45;
   localparam logic [7:0] ASCII_EQ   = 8'd61;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_TERM,
      ST_WAIT,
      ST_DONE
   } state_e;

   function automatic logic [7:0] tok2ascii(input logic [4:0] tok);
      logic [7:0] ch;
      ch = 8'd0;
      if (tok < 5'd10) begin
         ch = ASCII_0 + {3'b000, tok};
      end else if (tok < TOK_LPAR) begin
         ch = ASCII_A + {3'b000, tok} - 8'd10;
      end else begin
         case (tok)
            TOK_LPAR: ch = ASCII_LPAR;
            TOK_RPAR: ch = ASCII_RPAR;
            TOK_MUL:  ch = ASCII_MUL;
            TOK_ADD:  ch = ASCII_ADD;
            TOK_SUB:  ch = ASCII_SUB;
            default:  ch = 8'd0;
         endcase
      end
      return ch;
   endfunction

endpackage

// File: rtl/aec_tok_buf.sv
// Token register file: appends at the count index, reads by index, full when DEPTH tokens are held.
module aec_tok_buf
   import aec_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en_i,
   input  logic [4:0]                 wr_dat_i,
   input  logic                       clr_i,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
   output logic [4:0]                 rd_dat_o,
   output logic [$clog2(DEPTH):0]     cnt_o,
   output logic                       full_o
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [4:0]    mem_q [DEPTH];
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (wr_en_i) begin
         mem_q[cnt_q[IW-1:0]] <= wr_dat_i;
         cnt_q                <= cnt_q + CW'(1);
      end
   end

   assign rd_dat_o = mem_q[rd_idx_i];
   assign cnt_o    = cnt_q;
   assign full_o   = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/aec_expr_tx.sv
// Streams buffered expression tokens as ASCII plus '=' to the calculator, then captures its result or times out.
// AEC_TX_REPLAY_EN: buffer survives completion for retransmission and a clear port empties it.
module aec_expr_tx
   import aec_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
`ifdef AEC_TX_REPLAY_EN
   input  logic       clear,
`endif
   input  logic       tok_wr,
   input  logic [4:0] tok_in,
   output logic       tok_full,
   input  logic       start,
   output logic       busy,
   output logic [7:0] ascii_out,
   output logic       ready_out,
   input  logic       res_valid,
   input  logic [6:0] res_in,
   output logic       done,
   output logic [6:0] result,
   output logic       err
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] rd_q, rd_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    ascii_q, ascii_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [6:0]    result_q, result_d;

   logic          wr_en, buf_clr, clear_req;
   logic [4:0]    rd_dat;
   logic [CW-1:0] cnt;

`ifdef AEC_TX_REPLAY_EN
   assign clear_req = clear;
`else
   assign clear_req = 1'b0;
`endif

   aec_tok_buf #(.DEPTH(DEPTH)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (wr_en),
      .wr_dat_i (tok_in),
      .clr_i    (buf_clr),
      .rd_idx_i (rd_q[IW-1:0]),
      .rd_dat_o (rd_dat),
      .cnt_o    (cnt),
      .full_o   (tok_full)
   );

   always_comb begin
      state_d  = state_q;
      rd_d     = rd_q;
      tmo_d    = tmo_q;
      ascii_d  = 8'd0;
      ready_d  = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      result_d = result_q;
      wr_en    = 1'b0;
      buf_clr  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear_req) begin
               buf_clr = 1'b1;
            end else begin
               if (tok_wr && !tok_full) begin
                  if (tok_in > TOK_SUB) err_d = 1'b1;
                  else                  wr_en = 1'b1;
               end
               // rd is always 0 in IDLE, so rd_dat already holds the first token
               if (start) begin
                  if (cnt == '0) begin
                     err_d = 1'b1;
                  end else begin
                     state_d = ST_SEND;
                     ascii_d = tok2ascii(rd_dat);
                     ready_d = 1'b1;
                     rd_d    = CW'(1);
                  end
               end
            end
         end
         ST_SEND: begin
            if (rd_q == cnt) begin
               state_d = ST_TERM;
               ascii_d = ASCII_EQ;
            end else begin
               ascii_d = tok2ascii(rd_dat);
               rd_d    = rd_q + CW'(1);
            end
         end
         ST_TERM: begin
            state_d = ST_WAIT;
            tmo_d   = '0;
         end
         ST_WAIT: begin
            if (res_valid) begin
               result_d = res_in;
               done_d   = 1'b1;
               state_d  = ST_DONE;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            rd_d    = '0;
`ifndef AEC_TX_REPLAY_EN
            buf_clr = 1'b1;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rd_q     <= '0;
         tmo_q    <= '0;
         ascii_q  <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         rd_q     <= rd_d;
         tmo_q    <= tmo_d;
         ascii_q  <= ascii_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         err_q    <= err_d;
         result_q <= result_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign ascii_out = ascii_q;
   assign ready_out = ready_q;
   assign done      = done_q;
   assign err       = err_q;
   assign result    = result_q;

endmodule

// File: doc/aec_expr_tx.md
Name: aec_expr_tx

Overview:
- Expression transmitter that drives the ASCII arithmetic-expression calculator input port.
- A host loads expression tokens into an internal buffer and pulses start.
- The block then streams one ASCII character per cycle, marks the first character with ready_out, and appends '=' (61).
- It then waits for the calculator's valid/result, captures the result, and reports done or a timeout error.

Parameters:
- DEPTH, 16, token buffer entries (power of two, max expression length excluding '=').
- TIMEOUT, 255, max cycles in WAIT for res_valid before error.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- tok_wr  input  1  write tok_in into buffer (ignored when tok_full or busy)
- tok_in  input  5  token code: 0-15 hex digit, 16 '(', 17 ')', 18 '*', 19 '+', 20 '-'; 21-31 illegal
- tok_full  output  1  buffer holds DEPTH tokens
- start  input  1  begin transmission (sampled only in IDLE)
- busy  output  1  high in every state except IDLE
- ascii_out  output  8  character to calculator ascii_in
- ready_out  output  1  high only on the cycle carrying the first character
- res_valid  input  1  calculator result valid
- res_in  input  7  calculator result
- done  output  1  one-cycle pulse when result captured
- result  output  7  captured result, held until next capture
- err  output  1  one-cycle pulse: timeout, illegal token at load, or start with empty buffer

Behaviour:
- Reset values: all outputs 0, FSM IDLE, buffer count 0, read pointer 0.
- Load: in IDLE, tok_wr with !tok_full writes tok_in at the count index and increments count.
  - Illegal code (>20): not stored; err pulses next cycle; count unchanged.
  - tok_wr while full or busy: ignored silently.
- ASCII map: 0-9 -> 48-57; 10-15 -> 97-102; 16 -> 40; 17 -> 41; 18 -> 42; 19 -> 43; 20 -> 45; terminator 61.
- ascii_out is 0 in IDLE, WAIT and DONE. It must never idle at 61.
- FSM:
  - IDLE: start && count==0 -> err pulse, stay IDLE. start && count>0 -> SEND, rd=0.
  - SEND: registered ascii_out = map(buf[rd]), rd++. ready_out=1 only when rd==0. After emitting index count-1 -> TERM.
  - TERM: ascii_out=61 for exactly one cycle, ready_out=0 -> WAIT, clear timeout counter.
  - WAIT: res_valid -> result<=res_in, go DONE. Otherwise counter++; counter==TIMEOUT -> err pulse, go DONE without updating result.
  - DONE: done pulses (only on the capture path), clear count and rd -> IDLE.
- Latency: first character appears on ascii_out the cycle after start is sampled. The count characters plus '=' occupy count+1 consecutive cycles with no gaps.
- res_valid outside WAIT is ignored.
- start while busy is ignored.
- rst mid-operation returns to IDLE immediately: outputs 0, buffer discarded.
- Counters are sized $clog2(DEPTH)+1 and $clog2(TIMEOUT+1); no wrap occurs.

Optional Feature:
- Macro AEC_TX_REPLAY_EN.
- Defined: DONE clears only rd, not count. The buffer is retained, so the next start retransmits the same expression. A clear input port (1 bit, IDLE only) empties the buffer.
- Undefined: buffer always emptied in DONE; no clear port.

Decomposition:
- Package aec_pkg: token code localparams (TOK_LPAR..TOK_SUB), ASCII constants (ASCII_EQ=61 etc.), FSM state encoding, and the token-to-ASCII mapping function.
- Sub-module aec_tok_buf: DEPTH x 5 register file with write port, count, full flag and read-by-index.

Test Plan:
- Load 3,19,4,18,2; start -> ascii_out 51,43,52,42,50,61 on consecutive cycles; ready_out only with 51; res_valid with res_in=11 in WAIT -> done pulse, result=11.
- Load 16,10,20,2,17,18,3; start -> 40,97,45,50,41,42,51,61 streamed; res_in=24 -> result=24.
- Start with empty buffer -> err pulse, busy stays 0. tok_in=25 -> err pulse, count unchanged.
- Load 16 tokens -> tok_full=1; 17th write ignored; full stream is 16 chars plus 61.
- No res_valid after '=' -> err pulse after exactly TIMEOUT WAIT cycles; result keeps its old value.
- Assert rst during SEND -> ascii_out=0, busy=0 and tok_full=0 immediately. With AEC_TX_REPLAY_EN, a second start replays the identical stream.
